pixel_generator: RTL and testbench

- Streaming video source for the fractal accelerator.
- Emits one 32-bit pixel per AXI4-Stream beat in raster order over an X_SIZE x Y_SIZE frame, repeating frames indefinitely.
- A small AXI4-Lite register file holds control values; register 0 sets the blue channel.
- Sits between the PS control bus and the video DMA / VDMA stream input.

---
 rtl/pixel_generator.sv | 139 +++++++++++++
 tb/tb_pixel_generator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_generator.sv
// Raster-order AXI4-Stream pixel source with a small AXI4-Lite register file.
// Pixel = {8'h00, x[7:0], y[7:0], reg0[7:0]}; one beat per accepted handshake.
module pixel_generator #(
    parameter int unsigned X_SIZE        = 640,
    parameter int unsigned Y_SIZE        = 480,
    parameter int unsigned REG_FILE_SIZE = 8
) (
    input  logic        out_stream_aclk,
    input  logic        s_axi_lite_aclk,
    input  logic        axi_resetn,
    input  logic        periph_resetn,

    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    input  logic        out_stream_tready,
    output logic        out_stream_tvalid,
    output logic        out_stream_tuser,

    input  logic [7:0]  s_axi_lite_awaddr,
    input  logic        s_axi_lite_awvalid,
    output logic        s_axi_lite_awready,
    input  logic [31:0] s_axi_lite_wdata,
    input  logic        s_axi_lite_wvalid,
    output logic        s_axi_lite_wready,
    output logic [1:0]  s_axi_lite_bresp,
    output logic        s_axi_lite_bvalid,
    input  logic        s_axi_lite_bready,
    input  logic [7:0]  s_axi_lite_araddr,
    input  logic        s_axi_lite_arvalid,
    output logic        s_axi_lite_arready,
    output logic [31:0] s_axi_lite_rdata,
    output logic [1:0]  s_axi_lite_rresp,
    output logic        s_axi_lite_rvalid,
    input  logic        s_axi_lite_rready
);

    localparam int unsigned XW = $clog2(X_SIZE);
    localparam int unsigned YW = $clog2(Y_SIZE);
    localparam int unsigned IW = $clog2(REG_FILE_SIZE);

    wire clk = out_stream_aclk;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          tvalid_q;
    logic [31:0]   regs [REG_FILE_SIZE];

    logic          x_last;
    logic          y_last;
    logic [IW-1:0] widx;
    logic [IW-1:0] ridx;
    logic          wr_fire;
    logic          rd_fire;

    // Indices above the register count alias naturally by dropping upper address bits.
    assign widx    = s_axi_lite_awaddr[2 +: IW];
    assign ridx    = s_axi_lite_araddr[2 +: IW];
    assign x_last  = (x == XW'(X_SIZE - 1));
    assign y_last  = (y == YW'(Y_SIZE - 1));
    assign wr_fire = s_axi_lite_awvalid && s_axi_lite_awready && s_axi_lite_wvalid && s_axi_lite_wready;
    assign rd_fire = s_axi_lite_arvalid && s_axi_lite_arready;

    // Stream beat derived straight from the counters: zero-latency source, gated to 0 in reset.
    assign out_stream_tvalid = tvalid_q;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tdata  = tvalid_q ? {8'h00, 8'(x), 8'(y), regs[0][7:0]} : 32'h0;
    assign out_stream_tuser  = tvalid_q && (x == '0) && (y == '0);
    assign out_stream_tlast  = tvalid_q && x_last && y_last;

    assign s_axi_lite_bresp = 2'b00;
    assign s_axi_lite_rresp = 2'b00;

    // Raster counters advance on each accepted beat; frame wraps after the last pixel.
    always_ff @(posedge clk) begin
        if (!periph_resetn) begin
            x        <= '0;
            y        <= '0;
            tvalid_q <= 1'b0;
        end else begin
            tvalid_q <= 1'b1;
            if (tvalid_q && out_stream_tready) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // Write channel: address and data are accepted together, then a single OKAY response.
    always_ff @(posedge clk) begin
        if (!axi_resetn) begin
            s_axi_lite_awready <= 1'b0;
            s_axi_lite_wready  <= 1'b0;
            s_axi_lite_bvalid  <= 1'b0;
            for (int i = 0; i < int'(REG_FILE_SIZE); i++) regs[i] <= '0;
        end else begin
            s_axi_lite_awready <= 1'b0;
            s_axi_lite_wready  <= 1'b0;
            if (s_axi_lite_bvalid && s_axi_lite_bready) s_axi_lite_bvalid <= 1'b0;
            if (wr_fire) begin
                regs[widx]        <= s_axi_lite_wdata;
                s_axi_lite_bvalid <= 1'b1;
            end else if (s_axi_lite_awvalid && s_axi_lite_wvalid && !s_axi_lite_bvalid
                         && !s_axi_lite_awready) begin
                s_axi_lite_awready <= 1'b1;
                s_axi_lite_wready  <= 1'b1;
            end
        end
    end

    // Read channel: one-cycle arready pulse, data registered and held until rready.
    always_ff @(posedge clk) begin
        if (!axi_resetn) begin
            s_axi_lite_arready <= 1'b0;
            s_axi_lite_rvalid  <= 1'b0;
            s_axi_lite_rdata   <= '0;
        end else begin
            s_axi_lite_arready <= 1'b0;
            if (s_axi_lite_rvalid && s_axi_lite_rready) s_axi_lite_rvalid <= 1'b0;
            if (rd_fire) begin
                s_axi_lite_rdata  <= regs[ridx];
                s_axi_lite_rvalid <= 1'b1;
            end else if (s_axi_lite_arvalid && !s_axi_lite_rvalid && !s_axi_lite_arready) begin
                s_axi_lite_arready <= 1'b1;
            end
        end
    end

    // Second clock pin shares the stream clock net; ignored address bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = &{1'b0, s_axi_lite_aclk,
                           s_axi_lite_awaddr[7:2+IW], s_axi_lite_awaddr[1:0],
                           s_axi_lite_araddr[7:2+IW], s_axi_lite_araddr[1:0]};

endmodule

// File: tb/tb_pixel_generator.sv
// Directed bench for pixel_generator using a shortened 640x8 frame.
module tb_pixel_generator;

    localparam int XS = 640;
    localparam int YS = 8;

    logic        clk = 1'b0;
    logic        axi_resetn, periph_resetn;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tready, tvalid, tuser;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;

    int          total = 0;
    int          bad   = 0;
    int          beat  = 0;
    logic        exp_valid = 1'b0;
    logic [7:0]  b_exp = 8'h00;
    logic [31:0] rd;

    always #5 clk = ~clk;

    pixel_generator #(.X_SIZE(XS), .Y_SIZE(YS), .REG_FILE_SIZE(8)) dut (
        .out_stream_aclk(clk), .s_axi_lite_aclk(clk),
        .axi_resetn(axi_resetn), .periph_resetn(periph_resetn),
        .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
        .out_stream_tready(tready), .out_stream_tvalid(tvalid), .out_stream_tuser(tuser),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
        .s_axi_lite_rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the reference beat index follows accepted handshakes.
    task automatic tick();
        logic adv;
        adv = exp_valid && tready;
        @(posedge clk);
        #1;
        if (adv) beat++;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 20000 && beat < target; i++) tick();
    endtask

    function automatic logic [31:0] pix(input int b);
        int px, py;
        px = b % XS;
        py = (b / XS) % YS;
        return {8'h00, 8'(px), 8'(py), b_exp};
    endfunction

    task automatic chk_pix(input string tag);
        chk(tag, tdata, pix(beat));
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
        bit seen;
        seen = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (awready && wready) begin seen = 1; break; end
            tick();
        end
        chk("aw_handshake", 32'(seen), 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clr", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
        bit seen;
        seen = 0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (arready) begin seen = 1; break; end
            tick();
        end
        chk("ar_handshake", 32'(seen), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("rvalid", 32'(rvalid), 32'd1);
        chk("rresp", 32'(rresp), 32'd0);
        d = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        axi_resetn = 1'b0; periph_resetn = 1'b0; tready = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_tuser", 32'(tuser), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("tkeep", 32'(tkeep), 32'hF);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);

        // Release: first beat next cycle
        axi_resetn = 1'b1; periph_resetn = 1'b1;
        tick();
        exp_valid = 1'b1; beat = 0;
        chk("tvalid_up", 32'(tvalid), 32'd1);
        chk("beat0", tdata, 32'h0000_0000);
        chk("beat0_tuser", 32'(tuser), 32'd1);
        tick();
        chk("beat1", tdata, 32'h0001_0000);
        chk("beat1_tuser", 32'(tuser), 32'd0);

        // Backpressure at beat 10
        run_to(10);
        chk("bp_start", tdata, 32'h000A_0000);
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", tdata, 32'h000A_0000);
        end
        tready = 1'b1;
        tick();
        chk("bp_resume", tdata, 32'h000B_0000);

        // Line wrap
        run_to(639);
        chk("line_end", tdata, 32'h007F_0000);
        tick();
        chk("line_wrap", tdata, 32'h0000_0100);
        chk("wrap_tuser", 32'(tuser), 32'd0);
        chk("wrap_tlast", 32'(tlast), 32'd0);

        // Register write / read
        axi_write(8'h00, 32'h0000_00AB);
        b_exp = 8'hAB;
        chk_pix("reg0_blue");
        axi_read(8'h00, rd);
        chk("rd_reg0", rd, 32'h0000_00AB);
        axi_read(8'h04, rd);
        chk("rd_reg1", rd, 32'h0);
        axi_read(8'h23, rd);
        chk("rd_alias", rd, 32'h0000_00AB);
        axi_write(8'h1C, 32'h1234_5678);
        axi_read(8'h1C, rd);
        chk("rd_reg7", rd, 32'h1234_5678);
        chk_pix("pix_after_rw");

        // Frame end and next frame
        run_to(XS * YS - 2);
        chk("pre_last_tlast", 32'(tlast), 32'd0);
        tick();
        chk("last_tlast", 32'(tlast), 32'd1);
        chk("last_tdata", tdata, 32'h007F_07AB);
        tick();
        chk("frame2_tuser", 32'(tuser), 32'd1);
        chk("frame2_tdata", tdata, 32'h0000_00AB);
        chk("frame2_tlast", 32'(tlast), 32'd0);

        // Mid-frame reset at (100,5)
        run_to(XS * YS + 5 * XS + 100);
        chk("pix_100_5", tdata, 32'h0064_05AB);
        periph_resetn = 1'b0;
        tick();
        exp_valid = 1'b0; beat = 0;
        chk("mrst_tvalid", 32'(tvalid), 32'd0);
        chk("mrst_tdata", tdata, 32'h0);
        periph_resetn = 1'b1;
        tick();
        exp_valid = 1'b1;
        chk("mrst_resume", tdata, 32'h0000_00AB);
        chk("mrst_tuser", 32'(tuser), 32'd1);
        tick();
        chk("mrst_beat1", tdata, 32'h0001_00AB);

        // AXI reset clears registers without disturbing the stream
        run_to(700);
        axi_resetn = 1'b0;
        tick();
        b_exp = 8'h00;
        axi_resetn = 1'b1;
        chk_pix("arst_stream");
        chk("arst_tvalid", 32'(tvalid), 32'd1);
        axi_read(8'h00, rd);
        chk("arst_reg0", rd, 32'h0);
        axi_read(8'h1C, rd);
        chk("arst_reg7", rd, 32'h0);
        chk_pix("arst_stream_cont");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
